persiana_cmd_arbiter: RTL and testbench
=======================================

// Module: persiana_cmd_arbiter
// PURPOSE
//  Command scheduler in front of the automatic blind (persiana) Mealy FSM. It arbitrates
//  between three position requesters: wind safety, manual panel and automatic light/timer.
//  It drives the 2-bit target position consumed by the blind FSM.
//  It supervises travel using the motor feedback (subir/bajar) and the end/mid sensors,
//  and it enforces a minimum dwell time between accepted moves.
//  A travel timeout latches a fault.
// PARAMETERS
//  DWELL_CYC    1000   cycles held in DWELL after arrival before a new request is accepted
//  TIMEOUT_CYC  50000  max cycles in MOVE before arrival; reaching it latches fault
// PORTS
//  clk            in   1  system clock, rising edge
//  reset          in   1  asynchronous, active-high
//  req_wind       in   1  level; wind alarm, forces target TOP
//  req_man_valid  in   1  manual request strobe (1 cycle)
//  req_man_pos    in   2  manual target position
//  req_auto_valid in   1  automatic request strobe (1 cycle)
//  req_auto_pos   in   2  automatic target position
//  subir          in   1  motor-up active, from blind FSM
//  bajar          in   1  motor-down active, from blind FSM
//  sens_sup       in   1  top sensor
//  sens_med       in   1  middle sensor
//  sens_inf       in   1  bottom sensor
//  fault_clr      in   1  1-cycle pulse; leaves FAULT
//  pos_cmd        out  2  target position to blind FSM (P)
//  grant          out  3  one-hot 1-cycle accept pulse {wind,man,auto}
//  busy           out  1  high in MOVE or DWELL
//  fault          out  1  high in FAULT
// BEHAVIOUR
//  - Position encoding: 00 INF (bottom), 01 MED, 10 SUP (top). 11 is illegal; such requests are dropped, no grant.
//  - All inputs are synchronous to clk; no internal synchronisers or debounce.
//  - Reset (async): state IDLE, pos_cmd=00, grant=000, busy=0, fault=0, both timers cleared.
//    Reset mid-MOVE aborts immediately; pos_cmd=00 matches the blind FSM reset state.
//  - Request eligibility: legal position and target != pos_cmd. Ineligible strobes are dropped silently.
//  - Priority: wind > manual > auto. A lower-priority strobe in the same cycle is dropped, not queued.
//  - IDLE: on an eligible request, register pos_cmd on the next edge, pulse grant for that same cycle, and go to MOVE.
//    Latency is 1 cycle from strobe to pos_cmd and grant.
//  - MOVE: busy=1; travel timer counts every cycle.
//    Arrival = sensor matching pos_cmd (SUP->sens_sup, MED->sens_med, INF->sens_inf) AND subir=0 AND bajar=0.
//    On arrival -> DWELL, travel timer cleared.
//    Travel timer reaching TIMEOUT_CYC-1 without arrival -> FAULT.
//    If arrival and timeout occur in the same cycle, arrival wins.
//  - Preemption in MOVE:
//    - req_wind with pos_cmd!=10: retarget to 10, grant[2] pulses, travel timer restarts.
//    - An eligible manual strobe preempts only when the current move was granted to auto. It retargets, grant[1] pulses, timer restarts.
//    - Auto strobes are never accepted in MOVE.
//  - DWELL: busy=1; dwell timer counts to DWELL_CYC-1, then IDLE.
//    Manual and auto strobes are dropped.
//    req_wind with pos_cmd!=10 -> retarget and go to MOVE (wind bypasses dwell).
//  - While req_wind stays high in IDLE with pos_cmd=10, manual and auto requests are dropped.
//  - FAULT: fault=1, busy=0; pos_cmd held; all requests, including wind, are ignored.
//    fault_clr -> IDLE with fault=0 on the next edge.
//    If fault_clr and a timeout occur in the same cycle, FAULT holds.
//  - Timer width: $clog2(max(DWELL_CYC,TIMEOUT_CYC)+1) bits, unsigned; a timer never wraps because it is cleared on every state entry.
//  - grant is never multi-hot; grant=000 in every cycle without acceptance.
// STRUCTURE
//  - Package persiana_pkg:
//    - pos_t enum {POS_INF=2'b00, POS_MED=2'b01, POS_SUP=2'b10}
//    - arb_state_t enum {ST_IDLE, ST_MOVE, ST_DWELL, ST_FAULT}
//    - grant index constants GNT_WIND=2, GNT_MAN=1, GNT_AUTO=0
//  - One sub-module, persiana_cycle_timer (clr, en, limit -> expired), instantiated twice: travel and dwell.
//  - Arbitration is a combinational priority encoder plus a registered FSM in the top.
// TESTING (bench uses DWELL_CYC=8, TIMEOUT_CYC=20; blind FSM model in loop)
//  1 Reset then req_auto_valid pos=10 -> next cycle pos_cmd=10, grant=001, busy=1.
//    sens_sup=1 with motors idle -> DWELL for 8 cycles, then IDLE, busy=0.
//  2 Same cycle req_man_valid pos=01 and req_auto_valid pos=10 from IDLE -> pos_cmd=01, grant=010; auto dropped.
//  3 Auto move 00->10 in flight, manual strobe pos=01 -> pos_cmd=01, grant=010, timer restarts.
//    Repeat with a manual-granted move plus an auto strobe -> no change.
//  4 In DWELL with pos_cmd=01, raise req_wind -> pos_cmd=10, grant=100, state MOVE.
//    Manual strobes during wind -> no grant.
//  5 Request 00->10, sensors never assert -> fault=1 exactly 20 cycles after grant, pos_cmd held at 10.
//    Requests ignored; fault_clr -> fault=0, IDLE.
//  6 Request pos=11, request equal to pos_cmd, and async reset asserted mid-MOVE.
//    -> no grant for the first two; reset gives pos_cmd=00, busy=0 immediately.

Source files
------------

// File: rtl/persiana_pkg.sv
// Shared types, grant indices and small helpers for the persiana command arbiter.
package persiana_pkg;

  // Blind target positions; the numeric order follows physical height.
  typedef enum logic [1:0] {
    POS_INF = 2'b00,
    POS_MED = 2'b01,
    POS_SUP = 2'b10
  } pos_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_MOVE  = 2'b01,
    ST_DWELL = 2'b10,
    ST_FAULT = 2'b11
  } arb_state_t;

  // Bit positions inside the one-hot grant vector {wind, man, auto}.
  localparam int GNT_WIND = 2;
  localparam int GNT_MAN  = 1;
  localparam int GNT_AUTO = 0;

  // The 2'b11 code is not a position.
  function automatic logic pos_legal(input logic [1:0] p);
    return (p != 2'b11);
  endfunction

  // Sensor that confirms the blind stands at position p.
  function automatic logic sensor_hit(input logic [1:0] p, input logic s_sup,
                                      input logic s_med, input logic s_inf);
    logic hit;
    case (p)
      POS_SUP: hit = s_sup;
      POS_MED: hit = s_med;
      POS_INF: hit = s_inf;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/persiana_cycle_timer.sv
// Up-counter that flags when it has reached a programmed limit.
// The count saturates at the limit and is returned to zero by clr.
module persiana_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign expired = (count_q == limit);

  // Next count: clear wins, otherwise advance until the limit is reached.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !expired) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/persiana_cmd_arbiter.sv
// Command scheduler in front of the blind FSM: picks one of wind / manual /
// auto position requests, supervises travel against a timeout, and enforces a
// dwell period after each arrival. Wind is the safety path and bypasses dwell.
module persiana_cmd_arbiter
  import persiana_pkg::*;
#(
  parameter int DWELL_CYC   = 1000,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_wind,
  input  logic       req_man_valid,
  input  logic [1:0] req_man_pos,
  input  logic       req_auto_valid,
  input  logic [1:0] req_auto_pos,
  input  logic       subir,
  input  logic       bajar,
  input  logic       sens_sup,
  input  logic       sens_med,
  input  logic       sens_inf,
  input  logic       fault_clr,
  output logic [1:0] pos_cmd,
  output logic [2:0] grant,
  output logic       busy,
  output logic       fault
);

  localparam int TMR_MAX = (DWELL_CYC > TIMEOUT_CYC) ? DWELL_CYC : TIMEOUT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] DWELL_LIM = TMR_W'(DWELL_CYC - 1);
  localparam logic [TMR_W-1:0] TOUT_LIM  = TMR_W'(TIMEOUT_CYC - 1);

  arb_state_t state_q, state_d;
  logic [1:0] pos_cmd_q, pos_d;
  logic [2:0] grant_q, grant_d;
  logic       busy_q, fault_q;
  // Set when the move in flight was granted to the automatic requester,
  // which is the only case a manual strobe may preempt.
  logic       owner_auto_q, owner_auto_d;

  logic wind_ok_s, man_ok_s, auto_ok_s, arrived_s;
  logic travel_clr_s, travel_exp_s, dwell_clr_s, dwell_exp_s;

  // Eligibility of each requester against the current target.
  always_comb begin
    wind_ok_s = req_wind && (pos_cmd_q != POS_SUP);
    man_ok_s  = req_man_valid && pos_legal(req_man_pos) && (req_man_pos != pos_cmd_q);
    auto_ok_s = req_auto_valid && pos_legal(req_auto_pos) && (req_auto_pos != pos_cmd_q);
    arrived_s = sensor_hit(pos_cmd_q, sens_sup, sens_med, sens_inf) && !subir && !bajar;
  end

  // Priority arbitration and next-state logic.
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_cmd_q;
    grant_d      = 3'b000;
    owner_auto_d = owner_auto_q;
    case (state_q)
      ST_IDLE: begin
        if (wind_ok_s) begin
          grant_d[GNT_WIND] = 1'b1;
          pos_d             = POS_SUP;
          owner_auto_d      = 1'b0;
          state_d           = ST_MOVE;
        end else if (req_wind) begin
          // Wind holds the blind at the top: everything else is dropped.
          state_d = ST_IDLE;
        end else if (man_ok_s) begin
          grant_d[GNT_MAN] = 1'b1;
          pos_d            = req_man_pos;
          owner_auto_d     = 1'b0;
          state_d          = ST_MOVE;
        end else if (auto_ok_s) begin
          grant_d[GNT_AUTO] = 1'b1;
          pos_d             = req_auto_pos;
          owner_auto_d      = 1'b1;
          state_d           = ST_MOVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MOVE: begin
        if (wind_ok_s) begin
          grant_d[GNT_WIND] = 1'b1;
          pos_d             = POS_SUP;
          owner_auto_d      = 1'b0;
        end else if (man_ok_s && owner_auto_q && !req_wind) begin
          grant_d[GNT_MAN] = 1'b1;
          pos_d            = req_man_pos;
          owner_auto_d     = 1'b0;
        end else if (arrived_s) begin
          state_d = ST_DWELL;
        end else if (travel_exp_s) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_MOVE;
        end
      end
      ST_DWELL: begin
        if (wind_ok_s) begin
          grant_d[GNT_WIND] = 1'b1;
          pos_d             = POS_SUP;
          owner_auto_d      = 1'b0;
          state_d           = ST_MOVE;
        end else if (dwell_exp_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DWELL;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Timers restart on every state entry and on every retarget.
  always_comb begin
    travel_clr_s = !((state_q == ST_MOVE) && (state_d == ST_MOVE) && (grant_d == 3'b000));
    dwell_clr_s  = !((state_q == ST_DWELL) && (state_d == ST_DWELL));
  end

  persiana_cycle_timer #(.W(TMR_W)) u_travel_tmr (
    .clk     (clk),
    .reset   (reset),
    .clr     (travel_clr_s),
    .en      (state_q == ST_MOVE),
    .limit   (TOUT_LIM),
    .expired (travel_exp_s)
  );

  persiana_cycle_timer #(.W(TMR_W)) u_dwell_tmr (
    .clk     (clk),
    .reset   (reset),
    .clr     (dwell_clr_s),
    .en      (state_q == ST_DWELL),
    .limit   (DWELL_LIM),
    .expired (dwell_exp_s)
  );

  // State and registered outputs; reset target matches the blind FSM reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pos_cmd_q    <= 2'b00;
      grant_q      <= 3'b000;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      owner_auto_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_cmd_q    <= pos_d;
      grant_q      <= grant_d;
      busy_q       <= (state_d == ST_MOVE) || (state_d == ST_DWELL);
      fault_q      <= (state_d == ST_FAULT);
      owner_auto_q <= owner_auto_d;
    end
  end

  assign pos_cmd = pos_cmd_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_persiana_cmd_arbiter.sv
// Directed bench for persiana_cmd_arbiter with a small blind-motor model.
module tb_persiana_cmd_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_wind, req_man_valid, req_auto_valid;
  logic [1:0] req_man_pos, req_auto_pos;
  logic       subir, bajar, sens_sup, sens_med, sens_inf, fault_clr;
  logic [1:0] pos_cmd;
  logic [2:0] grant;
  logic       busy, fault;

  int total = 0;
  int bad   = 0;

  // Blind model: one position step every 3 motor cycles.
  logic       plant_on = 1'b0;
  int         blind_pos = 0;
  int         travel = 0;

  persiana_cmd_arbiter #(.DWELL_CYC(8), .TIMEOUT_CYC(20)) dut (
    .clk(clk), .reset(reset), .req_wind(req_wind),
    .req_man_valid(req_man_valid), .req_man_pos(req_man_pos),
    .req_auto_valid(req_auto_valid), .req_auto_pos(req_auto_pos),
    .subir(subir), .bajar(bajar), .sens_sup(sens_sup), .sens_med(sens_med),
    .sens_inf(sens_inf), .fault_clr(fault_clr),
    .pos_cmd(pos_cmd), .grant(grant), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic plant_step();
    if (blind_pos != int'(pos_cmd)) begin
      subir = (int'(pos_cmd) > blind_pos);
      bajar = (int'(pos_cmd) < blind_pos);
      travel++;
      if (travel == 3) begin
        blind_pos = subir ? blind_pos + 1 : blind_pos - 1;
        travel = 0;
      end
    end else begin
      subir = 1'b0;
      bajar = 1'b0;
      travel = 0;
    end
    sens_inf = (blind_pos == 0);
    sens_med = (blind_pos == 1);
    sens_sup = (blind_pos == 2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (plant_on) plant_step();
  endtask

  task automatic set_sens(input logic s_sup, input logic s_med, input logic s_inf);
    sens_sup = s_sup; sens_med = s_med; sens_inf = s_inf;
  endtask

  task automatic man(input logic [1:0] p);
    req_man_valid = 1'b1; req_man_pos = p;
    tick();
    req_man_valid = 1'b0;
  endtask

  task automatic auto_req(input logic [1:0] p);
    req_auto_valid = 1'b1; req_auto_pos = p;
    tick();
    req_auto_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    check_eq(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; req_wind = 1'b0; req_man_valid = 1'b0; req_auto_valid = 1'b0;
    req_man_pos = 2'b00; req_auto_pos = 2'b00; subir = 1'b0; bajar = 1'b0;
    fault_clr = 1'b0; set_sens(1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("rst_outs", {pos_cmd, grant, busy, fault}, {2'b00, 3'b000, 1'b0, 1'b0});

    // 1: auto to top, arrival only once motors stop, 8-cycle dwell
    auto_req(2'b10);
    check_eq("t1_grant", {pos_cmd, grant, busy}, {2'b10, 3'b001, 1'b1});
    tick();
    check_eq("t1_pulse", grant, 3'b000);
    set_sens(1'b1, 1'b0, 1'b0); subir = 1'b1;
    tick();
    subir = 1'b0;
    tick();
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
    check_eq("t1_dwell_len", n, 8);
    check_eq("t1_idle", {busy, fault}, 2'b00);

    // 2: manual beats auto in the same cycle
    req_auto_valid = 1'b1; req_auto_pos = 2'b00;
    man(2'b01);
    req_auto_valid = 1'b0;
    check_eq("t2_man_wins", {pos_cmd, grant}, {2'b01, 3'b010});
    set_sens(1'b0, 1'b1, 1'b0);
    tick();
    wait_idle("t2_done", 40);

    // 3: manual preempts auto move; travel timer restarts, then timeout
    set_sens(1'b0, 1'b0, 1'b0);
    auto_req(2'b10);
    check_eq("t3_auto", {pos_cmd, grant}, {2'b10, 3'b001});
    repeat (9) tick();
    man(2'b00);
    check_eq("t3_preempt", {pos_cmd, grant}, {2'b00, 3'b010});
    n = 0;
    while (!fault && n < 40) begin
      tick();
      n++;
    end
    check_eq("t3_fault_lat", n, 20);
    check_eq("t3_fault_outs", {pos_cmd, busy, fault}, {2'b00, 1'b0, 1'b1});
    req_wind = 1'b1;
    man(2'b10);
    req_wind = 1'b0;
    check_eq("t3_fault_ignore", {pos_cmd, grant, fault}, {2'b00, 3'b000, 1'b1});
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check_eq("t3_clr", {fault, busy, grant}, {1'b0, 1'b0, 3'b000});
    // manual-owned move is not preempted by auto
    man(2'b01);
    check_eq("t3_man", {pos_cmd, grant}, {2'b01, 3'b010});
    tick();
    auto_req(2'b10);
    check_eq("t3_auto_drop", {pos_cmd, grant, busy}, {2'b01, 3'b000, 1'b1});

    // 4: in dwell, manual dropped; wind bypasses dwell
    set_sens(1'b0, 1'b1, 1'b0);
    tick();
    tick();
    man(2'b00);
    check_eq("t4_dwell_drop", {pos_cmd, grant, busy}, {2'b01, 3'b000, 1'b1});
    req_wind = 1'b1;
    tick();
    check_eq("t4_wind", {pos_cmd, grant, busy}, {2'b10, 3'b100, 1'b1});
    man(2'b00);
    check_eq("t4_wind_move", {pos_cmd, grant}, {2'b10, 3'b000});
    set_sens(1'b1, 1'b0, 1'b0);
    tick();
    wait_idle("t4_done", 40);
    man(2'b01);
    check_eq("t4_wind_idle_man", {pos_cmd, grant, busy}, {2'b10, 3'b000, 1'b0});
    auto_req(2'b00);
    check_eq("t4_wind_idle_auto", {pos_cmd, grant, busy}, {2'b10, 3'b000, 1'b0});
    req_wind = 1'b0;

    // 6: illegal and same-position requests dropped; async reset mid-move
    man(2'b11);
    check_eq("t6_illegal", {pos_cmd, grant, busy}, {2'b10, 3'b000, 1'b0});
    auto_req(2'b10);
    check_eq("t6_same", {pos_cmd, grant, busy}, {2'b10, 3'b000, 1'b0});
    auto_req(2'b01);
    check_eq("t6_move", {pos_cmd, grant, busy}, {2'b01, 3'b001, 1'b1});
    tick();
    #1 reset = 1'b1;
    #1;
    check_eq("t6_async_rst", {pos_cmd, grant, busy, fault}, {2'b00, 3'b000, 1'b0, 1'b0});
    reset = 1'b0;

    // 7: blind model in the loop, wind then auto
    blind_pos = 0; travel = 0; plant_on = 1'b1;
    set_sens(1'b0, 1'b0, 1'b1); subir = 1'b0; bajar = 1'b0;
    req_wind = 1'b1;
    tick();
    check_eq("t7_wind", {pos_cmd, grant}, {2'b10, 3'b100});
    wait_idle("t7_wind_done", 60);
    check_eq("t7_blind_top", blind_pos, 2);
    req_wind = 1'b0;
    auto_req(2'b01);
    check_eq("t7_auto", {pos_cmd, grant}, {2'b01, 3'b001});
    wait_idle("t7_auto_done", 60);
    check_eq("t7_blind_mid", blind_pos, 1);
    check_eq("t7_no_fault", {31'd0, fault}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
